multi_button_press_detector: RTL and testbench



---
 rtl/multi_button_press_detector.sv | 147 ++++++++++++++
 tb/tb_multi_button_press_detector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_button_press_detector.sv
// Debounces N_BTN push-buttons, arbitrates one owner channel and emits step pulses
// with long-press auto-repeat. Optional repeat acceleration: define REPEAT_ACCEL_EN.
module multi_button_press_detector #(
   parameter int N_BTN       = 2,
   parameter int CH_W        = 1,
   parameter int DEBOUNCE_MS = 10,
   parameter int LONG_MS     = 500,
   parameter int REPEAT_MS   = 250,
   parameter int CNT_W       = 10,
   parameter int ACCEL_AFTER = 8
) (
   input  logic             clk_1kHz,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic             step,
   output logic [CH_W-1:0]  step_ch,
   output logic             long_active,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

   state_t           state;
   logic [N_BTN-1:0] btn_m;
   logic [N_BTN-1:0] btn_s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic             held;

   function automatic logic [CH_W-1:0] lowest_set(input logic [N_BTN-1:0] v);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   // step_ch doubles as the owned-channel register, so held always tracks the owner
   assign held = btn_s[step_ch];

   always_ff @(posedge clk_1kHz or negedge rst) begin
      if (!rst) begin
         btn_m <= '0;
         btn_s <= '0;
      end else begin
         btn_m <= btn_raw;
         btn_s <= btn_m;
      end
   end

`ifdef REPEAT_ACCEL_EN
   localparam int FAST_MS = (REPEAT_MS / 4 < 1) ? 1 : REPEAT_MS / 4;
   localparam int RC_W    = (ACCEL_AFTER < 1) ? 1 : $clog2(ACCEL_AFTER + 1);

   logic [RC_W-1:0] rep_cnt;
   logic            accel_on;

   assign accel_on = (rep_cnt >= RC_W'(ACCEL_AFTER));
   assign period   = accel_on ? CNT_W'(FAST_MS) : CNT_W'(REPEAT_MS);

   // Counts repeat steps up to ACCEL_AFTER, then holds; any exit from REPEAT clears it
   always_ff @(posedge clk_1kHz or negedge rst) begin
      if (!rst) begin
         rep_cnt <= '0;
      end else if (state != REPEAT) begin
         rep_cnt <= '0;
      end else if (held && (cnt == period) && !accel_on) begin
         rep_cnt <= rep_cnt + RC_W'(1);
      end
   end
`else
   logic unused_accel;
   assign unused_accel = ^ACCEL_AFTER;
   assign period       = CNT_W'(REPEAT_MS);
`endif

   always_ff @(posedge clk_1kHz or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         step        <= 1'b0;
         step_ch     <= '0;
         long_active <= 1'b0;
         busy        <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            IDLE: begin
               if (|btn_s) begin
                  step_ch <= lowest_set(btn_s);
                  cnt     <= CNT_W'(1);
                  busy    <= 1'b1;
                  state   <= DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (!held) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (cnt == CNT_W'(DEBOUNCE_MS)) begin
                  step  <= 1'b1;
                  cnt   <= CNT_W'(1);
                  state <= HELD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!held) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (cnt == CNT_W'(LONG_MS)) begin
                  step        <= 1'b1;
                  long_active <= 1'b1;
                  cnt         <= CNT_W'(1);
                  state       <= REPEAT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (!held) begin
                  cnt         <= '0;
                  busy        <= 1'b0;
                  long_active <= 1'b0;
                  state       <= IDLE;
               end else if (cnt == period) begin
                  step <= 1'b1;
                  cnt  <= CNT_W'(1);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               cnt         <= '0;
               busy        <= 1'b0;
               long_active <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multi_button_press_detector.sv
// Directed bench for multi_button_press_detector; build with REPEAT_ACCEL_EN for the accel scenario.
module tb_multi_button_press_detector;

`ifdef REPEAT_ACCEL_EN
   localparam int D  = 2;
   localparam int L  = 4;
   localparam int R  = 8;
   localparam int AA = 2;
`else
   localparam int D  = 10;
   localparam int L  = 500;
   localparam int R  = 250;
   localparam int AA = 8;
`endif

   logic       clk_1kHz = 1'b0;
   logic       rst;
   logic [1:0] btn_raw;
   logic       step;
   logic [0:0] step_ch;
   logic       long_active;
   logic       busy;

   int tests = 0;
   int fails = 0;

   always #5 clk_1kHz = ~clk_1kHz;

   multi_button_press_detector #(
      .N_BTN(2), .CH_W(1), .DEBOUNCE_MS(D), .LONG_MS(L),
      .REPEAT_MS(R), .CNT_W(10), .ACCEL_AFTER(AA)
   ) dut (
      .clk_1kHz(clk_1kHz),
      .rst(rst),
      .btn_raw(btn_raw),
      .step(step),
      .step_ch(step_ch),
      .long_active(long_active),
      .busy(busy)
   );

   task automatic idle_wait(input int n);
      btn_raw = 2'b00;
      repeat (n) @(negedge clk_1kHz);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      btn_raw = 2'b00;
      #1;
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", step); end
      tests++; if (step_ch !== 1'b0) begin fails++; $display("FAIL reset_step_ch: got %b want 0", step_ch); end
      tests++; if (long_active !== 1'b0) begin fails++; $display("FAIL reset_long: got %b want 0", long_active); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      repeat (3) @(negedge clk_1kHz);
      rst = 1'b1;
      repeat (3) @(negedge clk_1kHz);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

`ifdef REPEAT_ACCEL_EN
   task automatic test_accel();
      int st[$];
      int exp_t[6] = '{5, 9, 17, 25, 27, 29};
      int got;
      btn_raw = 2'b01;
      for (int t = 1; t <= 70; t++) begin
         @(negedge clk_1kHz);
         if (step) st.push_back(t);
         if (t == 60) btn_raw = 2'b00;
      end
      for (int i = 0; i < 6; i++) begin
         got = (i < st.size()) ? st[i] : -1;
         tests++; if (got !== exp_t[i]) begin fails++; $display("FAIL accel_step%0d: got t=%0d want t=%0d", i, got, exp_t[i]); end
      end
      tests++; if (st.size() !== 22) begin fails++; $display("FAIL accel_count: got %0d want 22", st.size()); end
      idle_wait(10);
      st.delete();
      btn_raw = 2'b01;
      for (int t = 1; t <= 26; t++) begin
         @(negedge clk_1kHz);
         if (step) st.push_back(t);
      end
      got = (st.size() > 3) ? st[3] - st[2] : -1;
      tests++; if (got !== 8) begin fails++; $display("FAIL accel_cleared: got period %0d want 8", got); end
      idle_wait(10);
   endtask
`else
   task automatic test_long_hold();
      int st[$];
      int sc[$];
      int exp_t[3] = '{13, 513, 763};
      int busy_up = -1, busy_dn = -1, la_up = -1, la_dn = -1, got;
      btn_raw = 2'b01;
      for (int t = 1; t <= 1040; t++) begin
         @(negedge clk_1kHz);
         if (step) begin st.push_back(t); sc.push_back(int'(step_ch)); end
         if (busy && busy_up < 0) busy_up = t;
         if (!busy && busy_up >= 0 && busy_dn < 0) busy_dn = t;
         if (long_active && la_up < 0) la_up = t;
         if (!long_active && la_up >= 0 && la_dn < 0) la_dn = t;
         if (t == 1000) btn_raw = 2'b00;
      end
      tests++; if (busy_up !== 3) begin fails++; $display("FAIL long_busy_up: got t=%0d want t=3", busy_up); end
      tests++; if (st.size() !== 3) begin fails++; $display("FAIL long_count: got %0d want 3", st.size()); end
      for (int i = 0; i < 3; i++) begin
         got = (i < st.size()) ? st[i] : -1;
         tests++; if (got !== exp_t[i]) begin fails++; $display("FAIL long_step%0d: got t=%0d want t=%0d", i, got, exp_t[i]); end
         got = (i < sc.size()) ? sc[i] : -1;
         tests++; if (got !== 0) begin fails++; $display("FAIL long_ch%0d: got %0d want 0", i, got); end
      end
      tests++; if (la_up !== 513) begin fails++; $display("FAIL long_la_up: got t=%0d want t=513", la_up); end
      tests++; if (la_dn !== 1003) begin fails++; $display("FAIL long_la_dn: got t=%0d want t=1003", la_dn); end
      tests++; if (busy_dn !== 1003) begin fails++; $display("FAIL long_busy_dn: got t=%0d want t=1003", busy_dn); end
   endtask

   task automatic test_glitch();
      int steps = 0, busy_dn = -1;
      bit saw_busy = 0;
      btn_raw = 2'b10;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk_1kHz);
         if (step) steps++;
         if (busy) saw_busy = 1;
         if (!busy && saw_busy && busy_dn < 0) busy_dn = t;
         if (t == 6) btn_raw = 2'b00;
      end
      tests++; if (steps !== 0) begin fails++; $display("FAIL glitch_steps: got %0d want 0", steps); end
      tests++; if (saw_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_seen: got %b want 1", saw_busy); end
      tests++; if (busy_dn !== 9) begin fails++; $display("FAIL glitch_busy_dn: got t=%0d want t=9", busy_dn); end
   endtask

   task automatic test_simultaneous();
      int st[$];
      int sc[$];
      logic busy23 = 1'b1, busy24 = 1'b0;
      int got;
      btn_raw = 2'b11;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk_1kHz);
         if (step) begin st.push_back(t); sc.push_back(int'(step_ch)); end
         if (t == 23) busy23 = busy;
         if (t == 24) busy24 = busy;
         if (t == 20) btn_raw = 2'b10;
      end
      tests++; if (st.size() !== 2) begin fails++; $display("FAIL simul_count: got %0d want 2", st.size()); end
      got = (st.size() > 0) ? st[0] : -1;
      tests++; if (got !== 13) begin fails++; $display("FAIL simul_step0: got t=%0d want t=13", got); end
      got = (sc.size() > 0) ? sc[0] : -1;
      tests++; if (got !== 0) begin fails++; $display("FAIL simul_ch0: got %0d want 0", got); end
      tests++; if (busy23 !== 1'b0) begin fails++; $display("FAIL simul_idle_gap: got %b want 0", busy23); end
      tests++; if (busy24 !== 1'b1) begin fails++; $display("FAIL simul_reown: got %b want 1", busy24); end
      got = (st.size() > 1) ? st[1] : -1;
      tests++; if (got !== 34) begin fails++; $display("FAIL simul_step1: got t=%0d want t=34", got); end
      got = (sc.size() > 1) ? sc[1] : -1;
      tests++; if (got !== 1) begin fails++; $display("FAIL simul_ch1: got %0d want 1", got); end
      idle_wait(10);
   endtask

   task automatic test_ignore_other();
      int st[$];
      int bad_ch = 0, got;
      btn_raw = 2'b01;
      for (int t = 1; t <= 620; t++) begin
         @(negedge clk_1kHz);
         if (step) st.push_back(t);
         if (busy && step_ch !== 1'b0) bad_ch++;
         if (t >= 5 && t < 600 && (t % 3) == 0) btn_raw[1] = ~btn_raw[1];
         if (t == 600) btn_raw = 2'b00;
      end
      tests++; if (bad_ch !== 0) begin fails++; $display("FAIL ignore_ch: got %0d bad cycles want 0", bad_ch); end
      tests++; if (st.size() !== 2) begin fails++; $display("FAIL ignore_count: got %0d want 2", st.size()); end
      got = (st.size() > 1) ? st[1] : -1;
      tests++; if (got !== 513) begin fails++; $display("FAIL ignore_step1: got t=%0d want t=513", got); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_end_busy: got %b want 0", busy); end
   endtask

   task automatic test_reset_mid_press();
      int st[$];
      int la_up = -1, got;
      btn_raw = 2'b01;
      repeat (800) @(negedge clk_1kHz);
      tests++; if (long_active !== 1'b1) begin fails++; $display("FAIL rmid_pre_long: got %b want 1", long_active); end
      rst = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_async_busy: got %b want 0", busy); end
      tests++; if (long_active !== 1'b0) begin fails++; $display("FAIL rmid_async_long: got %b want 0", long_active); end
      tests++; if (step !== 1'b0) begin fails++; $display("FAIL rmid_async_step: got %b want 0", step); end
      repeat (3) @(negedge clk_1kHz);
      rst = 1'b1;
      for (int t = 1; t <= 520; t++) begin
         @(negedge clk_1kHz);
         if (step) st.push_back(t);
         if (long_active && la_up < 0) la_up = t;
      end
      got = (st.size() > 0) ? st[0] : -1;
      tests++; if (got !== 13) begin fails++; $display("FAIL rmid_step0: got t=%0d want t=13", got); end
      tests++; if (la_up !== 513) begin fails++; $display("FAIL rmid_la_up: got t=%0d want t=513", la_up); end
      tests++; if (st.size() !== 2) begin fails++; $display("FAIL rmid_count: got %0d want 2", st.size()); end
      idle_wait(10);
   endtask
`endif

   initial begin
      test_reset();
`ifdef REPEAT_ACCEL_EN
      test_accel();
`else
      test_long_hold();
      test_glitch();
      test_simultaneous();
      test_ignore_other();
      test_reset_mid_press();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
